enemy_formation_ctrl: RTL



---
 rtl/enemy_formation_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl: alien formation sequencer owning origin, alive mask, march direction and cadence.
// Invasion is detected on the step edge and latched so the pulse lands one cycle after the step is visible.
module enemy_formation_ctrl #(
    parameter int NUM_COLS    = 6,
    parameter int NUM_ROWS    = 3,
    parameter int COL_PITCH   = 60,
    parameter int ROW_PITCH   = 55,
    parameter int SPRITE_W    = 50,
    parameter int SPRITE_H    = 50,
    parameter int INIT_X      = 20,
    parameter int INIT_Y      = 40,
    parameter int LEFT_BOUND  = 0,
    parameter int RIGHT_BOUND = 639,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 16,
    parameter int INVADE_Y    = 420,
    parameter int MIN_PERIOD  = 2
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_tick,
    input  logic                           start,
    input  logic                           delete_enemies,
    input  logic                           hit_valid,
    input  logic [4:0]                     hit_index,
    output logic [9:0]                     formation_x,
    output logic [9:0]                     formation_y,
    output logic                           enemy_direction_X,
    output logic                           enemy_direction_Y,
    output logic [NUM_ROWS*NUM_COLS-1:0]   alive,
    output logic                           is_playing,
    output logic                           wave_cleared,
    output logic                           invaded
);
    localparam int TOTAL = NUM_ROWS*NUM_COLS;
    localparam logic [10:0] CP   = 11'(COL_PITCH);
    localparam logic [10:0] RP   = 11'(ROW_PITCH);
    localparam logic [10:0] SWM1 = 11'(SPRITE_W-1);
    localparam logic [10:0] SHM1 = 11'(SPRITE_H-1);
    localparam logic [10:0] LB   = 11'(LEFT_BOUND);
    localparam logic [10:0] RB   = 11'(RIGHT_BOUND);
    localparam logic [10:0] SX   = 11'(STEP_X);
    localparam logic [10:0] IVY  = 11'(INVADE_Y);
    localparam logic [9:0]  SX10 = 10'(STEP_X);
    localparam logic [9:0]  SY10 = 10'(STEP_Y);
    localparam logic [9:0]  X0   = 10'(INIT_X);
    localparam logic [9:0]  Y0   = 10'(INIT_Y);
    localparam logic [7:0]  MINP = 8'(MIN_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t             r_state;
    logic [9:0]         r_x, r_y;
    logic               r_dx, r_dy, r_cleared, r_invaded, r_pend;
    logic [TOTAL-1:0]   r_alive;
    logic [7:0]         r_cnt;

    logic [7:0]         w_pop, w_period;
    logic [NUM_COLS-1:0] w_colv;
    logic [NUM_ROWS-1:0] w_rowv;
    logic [4:0]         w_lc, w_rc, w_br;
    logic [10:0]        w_l, w_r, w_bot;
    logic               w_drop, w_step, w_inv;
    logic [9:0]         w_nx, w_ny;
    logic [TOTAL-1:0]   w_hmask;

    always_comb begin
        w_pop  = '0;
        w_colv = '0;
        w_rowv = '0;
        w_lc   = '0;
        w_rc   = '0;
        w_br   = '0;
        for (int i = 0; i < TOTAL; i++) w_pop = w_pop + 8'(r_alive[i]);
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++) begin
                w_colv[c] = w_colv[c] | r_alive[r*NUM_COLS+c];
                w_rowv[r] = w_rowv[r] | r_alive[r*NUM_COLS+c];
            end
        for (int c = NUM_COLS-1; c >= 0; c--) if (w_colv[c]) w_lc = 5'(c);
        for (int c = 0; c < NUM_COLS; c++) if (w_colv[c]) w_rc = 5'(c);
        for (int r = 0; r < NUM_ROWS; r++) if (w_rowv[r]) w_br = 5'(r);
    end

    // The >= lets a period that shrank mid-count still fire on the next tick.
    assign w_period = MINP + {2'b0, w_pop[7:2]};
    assign w_step   = (r_state == S_PLAY) && frame_tick && (r_cnt >= w_period - 8'd1);
    assign w_l      = {1'b0, r_x} + 11'(w_lc) * CP;
    assign w_r      = {1'b0, r_x} + 11'(w_rc) * CP + SWM1;
    assign w_drop   = r_dx ? (w_r + SX > RB) : (w_l < LB + SX);
    assign w_nx     = w_drop ? r_x : (r_dx ? r_x + SX10 : r_x - SX10);
    assign w_ny     = w_drop ? r_y + SY10 : r_y;
    assign w_bot    = {1'b0, w_ny} + 11'(w_br) * RP + SHM1;
    assign w_inv    = (|r_alive) && (w_bot >= IVY);
    assign w_hmask  = (hit_valid && ({1'b0, hit_index} < 6'(TOTAL))) ? (TOTAL'(1) << hit_index) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_x       <= X0;
            r_y       <= Y0;
            r_dx      <= 1'b1;
            r_dy      <= 1'b0;
            r_alive   <= '0;
            r_cnt     <= '0;
            r_cleared <= 1'b0;
            r_invaded <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            r_cleared <= 1'b0;
            r_invaded <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (delete_enemies) begin
                        r_alive <= '0;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_pend) begin
                        r_invaded <= 1'b1;
                        r_alive   <= r_alive & ~w_hmask;
                        r_cnt     <= '0;
                        r_pend    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (r_alive == '0) begin
                        r_cleared <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_alive <= r_alive & ~w_hmask;
                        if (w_step) begin
                            r_cnt  <= '0;
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_dx   <= r_dx ^ w_drop;
                            r_dy   <= w_drop;
                            r_pend <= w_inv;
                        end else if (frame_tick) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    if (start) begin
                        r_alive <= '1;
                        r_x     <= X0;
                        r_y     <= Y0;
                        r_dx    <= 1'b1;
                        r_dy    <= 1'b0;
                        r_state <= S_PLAY;
                    end
                end
            endcase
        end
    end

    assign formation_x       = r_x;
    assign formation_y       = r_y;
    assign enemy_direction_X = r_dx;
    assign enemy_direction_Y = r_dy;
    assign alive             = r_alive;
    assign is_playing        = (r_state == S_PLAY);
    assign wave_cleared      = r_cleared;
    assign invaded           = r_invaded;
endmodule
